// File: rtl/pong_pkg.sv
// Shared paddle-subsystem types: widths, button bits, CPU FSM states.
// Also carries the absolute-difference helper used for distances.
package pong_pkg;

  localparam int X_W = 8;
  localparam int Y_W = 9;

  localparam int BTN_DOWN  = 0;
  localparam int BTN_UP    = 1;
  localparam int BTN_LEFT  = 2;
  localparam int BTN_RIGHT = 3;

  localparam int DEF_HOME_X      = 115;
  localparam int DEF_HOME_Y      = 240;
  localparam int DEF_DEAD_ZONE   = 2;
  localparam int DEF_STRIKE_DIST = 20;
  localparam int DEF_REACT_TICKS = 6;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WAIT   = 3'd1,
    ST_TRACK  = 3'd2,
    ST_STRIKE = 3'd3,
    ST_RETURN = 3'd4
  } state_e;

  // Compare first, then subtract, so no signed wrap is possible.
  function automatic logic [Y_W-1:0] absdiff(
    input logic [Y_W-1:0] a,
    input logic [Y_W-1:0] b
  );
    return (a >= b) ? (a - b) : (b - a);
  endfunction

endpackage

// File: rtl/cpu_paddle_driver_if.sv
// Bundle between the ball/paddle logic and the CPU paddle driver.
// master drives ball/paddle/strobe, slave returns buttons and state.
interface cpu_paddle_driver_if;
  import pong_pkg::*;

  logic           enable;
  logic           tick;
  logic [X_W-1:0] ballXValue;
  logic [Y_W-1:0] ballYValue;
  logic [X_W-1:0] paddleXValue;
  logic [Y_W-1:0] paddleYValue;
  logic [3:0]     button;
  logic [2:0]     state;

  modport master (
    output enable,
    output tick,
    output ballXValue,
    output ballYValue,
    output paddleXValue,
    output paddleYValue,
    input  button,
    input  state
  );

  modport slave (
    input  enable,
    input  tick,
    input  ballXValue,
    input  ballYValue,
    input  paddleXValue,
    input  paddleYValue,
    output button,
    output state
  );

endinterface

// File: rtl/axis_steer.sv
// One-axis steering: active-low {minus, plus} from target vs position.
// Errors within the dead zone release both buttons.
module axis_steer #(
  parameter int W = 8
) (
  input  logic [W-1:0] i_target,
  input  logic [W-1:0] i_pos,
  input  logic [W-1:0] i_dead,
  output logic         o_minus_n,
  output logic         o_plus_n
);

  logic         w_ahead;
  logic [W-1:0] w_diff;

  assign w_ahead = (i_target > i_pos);
  assign w_diff  = w_ahead ? (i_target - i_pos)
                           : (i_pos - i_target);

  always_comb begin
    o_minus_n = 1'b1;
    o_plus_n  = 1'b1;
    if (w_diff > i_dead) begin
      if (w_ahead) o_plus_n  = 1'b0;
      else         o_minus_n = 1'b0;
    end
  end

endmodule

// File: rtl/cpu_paddle_driver.sv
// Computer opponent: per-tick FSM that presses the paddle-mover
// buttons so the second paddle tracks and strikes the ball.
module cpu_paddle_driver
  import pong_pkg::*;
#(
  parameter int HOME_X         = DEF_HOME_X,
  parameter int HOME_Y         = DEF_HOME_Y,
  parameter int DEAD_ZONE      = DEF_DEAD_ZONE,
  parameter int STRIKE_DIST    = DEF_STRIKE_DIST,
  parameter int REACTION_TICKS = DEF_REACT_TICKS
) (
  input  logic                clock,
  input  logic                reset,
  cpu_paddle_driver_if.slave  bus
);

  localparam logic [X_W-1:0] L_HX   = X_W'(HOME_X);
  localparam logic [Y_W-1:0] L_HY   = Y_W'(HOME_Y);
  localparam logic [X_W-1:0] L_DZX  = X_W'(DEAD_ZONE);
  localparam logic [Y_W-1:0] L_DZY  = Y_W'(DEAD_ZONE);
  localparam logic [Y_W-1:0] L_SD   = Y_W'(STRIKE_DIST);
  localparam logic [4:0]     L_RT   = 5'(REACTION_TICKS);

  state_e         r_state;
  logic [3:0]     r_button;
  logic [3:0]     r_cnt;
  logic [Y_W-1:0] r_prev_dist;
  logic           r_appr;

  state_e         w_state_nx;
  logic [3:0]     w_cnt_nx;
  logic [Y_W-1:0] w_dist;
  logic           w_appr_nx;
  logic           w_wait_done;
  logic           w_home;
  logic           w_steer;
  logic [X_W-1:0] w_tgt_x;
  logic [Y_W-1:0] w_tgt_y;
  logic           w_x_minus_n;
  logic           w_x_plus_n;
  logic           w_y_minus_n;
  logic           w_y_plus_n;
  logic [3:0]     w_button_nx;

  assign w_dist = absdiff(bus.ballYValue, bus.paddleYValue);

  assign w_wait_done =
    ({1'b0, r_cnt} + 5'd1 >= L_RT);

  assign w_home =
    (absdiff({1'b0, bus.paddleXValue}, {1'b0, L_HX})
       <= L_DZY) &&
    (absdiff(bus.paddleYValue, L_HY) <= L_DZY);

  always_comb begin
    w_appr_nx = r_appr;
    if (w_dist < r_prev_dist)
      w_appr_nx = 1'b1;
    else if (w_dist > r_prev_dist)
      w_appr_nx = 1'b0;
  end

  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    if (!bus.enable) begin
      w_state_nx = ST_IDLE;
      w_cnt_nx   = '0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (r_appr) begin
            w_state_nx = ST_WAIT;
            w_cnt_nx   = '0;
          end
        end
        ST_WAIT: begin
          w_cnt_nx = r_cnt + 4'd1;
          if (w_wait_done)
            w_state_nx = ST_TRACK;
          else if (!r_appr)
            w_state_nx = ST_RETURN;
        end
        ST_TRACK: begin
          if (w_dist <= L_SD)
            w_state_nx = ST_STRIKE;
          else if (!r_appr)
            w_state_nx = ST_RETURN;
        end
        ST_STRIKE: begin
          if (!r_appr)
            w_state_nx = ST_RETURN;
        end
        ST_RETURN: begin
          if (r_appr) begin
            w_state_nx = ST_WAIT;
            w_cnt_nx   = '0;
          end else if (w_home) begin
            w_state_nx = ST_IDLE;
          end
        end
        default: w_state_nx = ST_IDLE;
      endcase
    end
  end

  // Targets follow the state being entered, not the one being left.
  always_comb begin
    w_steer = 1'b0;
    w_tgt_x = L_HX;
    w_tgt_y = L_HY;
    unique case (w_state_nx)
      ST_TRACK: begin
        w_steer = 1'b1;
        w_tgt_x = bus.ballXValue;
      end
      ST_STRIKE: begin
        w_steer = 1'b1;
        w_tgt_x = bus.ballXValue;
        w_tgt_y = bus.ballYValue;
      end
      ST_RETURN: w_steer = 1'b1;
      default:   w_steer = 1'b0;
    endcase
  end

  axis_steer #(.W(X_W)) u_steer_x (
    .i_target  (w_tgt_x),
    .i_pos     (bus.paddleXValue),
    .i_dead    (L_DZX),
    .o_minus_n (w_x_minus_n),
    .o_plus_n  (w_x_plus_n)
  );

  axis_steer #(.W(Y_W)) u_steer_y (
    .i_target  (w_tgt_y),
    .i_pos     (bus.paddleYValue),
    .i_dead    (L_DZY),
    .o_minus_n (w_y_minus_n),
    .o_plus_n  (w_y_plus_n)
  );

  always_comb begin
    w_button_nx = 4'hF;
    if (w_steer) begin
      w_button_nx[BTN_RIGHT] = w_x_plus_n;
      w_button_nx[BTN_LEFT]  = w_x_minus_n;
      w_button_nx[BTN_UP]    = w_y_minus_n;
      w_button_nx[BTN_DOWN]  = w_y_plus_n;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_button    <= 4'hF;
      r_cnt       <= '0;
      r_prev_dist <= '1;
      r_appr      <= 1'b0;
    end else if (bus.tick) begin
      r_state     <= w_state_nx;
      r_button    <= w_button_nx;
      r_cnt       <= w_cnt_nx;
      r_prev_dist <= w_dist;
      r_appr      <= w_appr_nx;
    end
  end

  assign bus.button = r_button;
  assign bus.state  = r_state;

  a_no_opposed: assert property (
    @(posedge clock) disable iff (!reset)
    (r_button[BTN_UP]   | r_button[BTN_DOWN]) &&
    (r_button[BTN_LEFT] | r_button[BTN_RIGHT])
  );

endmodule

// File: tb/tb_cpu_paddle_driver.sv
// Directed bench for the CPU paddle driver.
// Hand-computed button/state expectations per tick.
module tb_cpu_paddle_driver;
  import pong_pkg::*;

  logic clk;
  logic rst_n;
  int   n_run;
  int   n_fail;

  cpu_paddle_driver_if bus ();

  cpu_paddle_driver dut (
    .clock (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", tag, got, exp);
    end
  endtask

  task automatic set_in(
    input logic [7:0] bx,
    input logic [8:0] by,
    input logic [7:0] px,
    input logic [8:0] py
  );
    bus.ballXValue   = bx;
    bus.ballYValue   = by;
    bus.paddleXValue = px;
    bus.paddleYValue = py;
  endtask

  task automatic do_tick(
    input logic [7:0] bx,
    input logic [8:0] by,
    input logic [7:0] px,
    input logic [8:0] py
  );
    @(negedge clk);
    set_in(bx, by, px, py);
    bus.tick = 1'b1;
    @(negedge clk);
    bus.tick = 1'b0;
  endtask

  // Back-to-back ticks, ball Y stepping down by 1 each cycle.
  task automatic tick_burst(input logic [8:0] by0, input int n);
    @(negedge clk);
    for (int i = 0; i < n; i++) begin
      set_in(8'd100, by0 - 9'(i), 8'd115, 9'd240);
      bus.tick = 1'b1;
      @(negedge clk);
    end
    bus.tick = 1'b0;
  endtask

  initial begin
    n_run  = 0;
    n_fail = 0;
    rst_n  = 1'b0;
    bus.enable = 1'b1;
    bus.tick   = 1'b0;
    set_in(8'd100, 9'd300, 8'd115, 9'd240);
    repeat (3) @(negedge clk);
    chk("rst_btn", bus.button, 4'hF);
    chk("rst_st", bus.state, 3'd0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("idle_btn", bus.button, 4'hF);
    chk("idle_st", bus.state, 3'd0);

    do_tick(8'd100, 9'd300, 8'd115, 9'd240);
    chk("t1_st", bus.state, 3'd0);
    do_tick(8'd100, 9'd298, 8'd115, 9'd240);
    chk("t2_wait", bus.state, 3'd1);
    chk("t2_btn", bus.button, 4'hF);
    for (int i = 0; i < 5; i++)
      do_tick(8'd100, 9'(296 - 2 * i), 8'd115, 9'd240);
    chk("t7_wait", bus.state, 3'd1);
    chk("t7_cnt", dut.r_cnt, 4'd5);
    do_tick(8'd100, 9'd286, 8'd115, 9'd240);
    chk("t8_track", bus.state, 3'd2);
    chk("t8_btn", bus.button, 4'b1011);
    repeat (3) @(negedge clk);
    chk("t8_hold", bus.button, 4'b1011);

    do_tick(8'd100, 9'd255, 8'd115, 9'd240);
    chk("strike_st", bus.state, 3'd3);
    chk("strike_btn", bus.button, 4'b1010);
    do_tick(8'd113, 9'd238, 8'd115, 9'd240);
    chk("dz_neg_btn", bus.button, 4'hF);
    chk("dz_neg_st", bus.state, 3'd3);
    do_tick(8'd117, 9'd242, 8'd115, 9'd240);
    chk("dz_pos_btn", bus.button, 4'hF);
    do_tick(8'd100, 9'd225, 8'd115, 9'd240);
    chk("strk_up", bus.button[BTN_UP], 1'b0);
    chk("strk_dn", bus.button[BTN_DOWN], 1'b1);
    chk("strk_btn", bus.button, 4'b1001);

    @(negedge clk);
    bus.enable = 1'b0;
    repeat (3) @(negedge clk);
    chk("en_late_st", bus.state, 3'd3);
    chk("en_late_btn", bus.button, 4'b1001);
    do_tick(8'd100, 9'd225, 8'd115, 9'd240);
    chk("en_off_st", bus.state, 3'd0);
    chk("en_off_btn", bus.button, 4'hF);

    bus.enable = 1'b1;
    do_tick(8'd100, 9'd230, 8'd115, 9'd240);
    chk("b1_st", bus.state, 3'd0);
    do_tick(8'd100, 9'd232, 8'd115, 9'd240);
    chk("b2_wait", bus.state, 3'd1);
    do_tick(8'd100, 9'd233, 8'd115, 9'd240);
    chk("b3_cnt", dut.r_cnt, 4'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_btn", bus.button, 4'hF);
    chk("arst_st", bus.state, 3'd0);
    chk("arst_cnt", dut.r_cnt, 4'd0);
    @(negedge clk);
    rst_n = 1'b1;

    do_tick(8'd100, 9'd300, 8'd115, 9'd240);
    chk("c1_st", bus.state, 3'd0);
    do_tick(8'd100, 9'd290, 8'd115, 9'd240);
    chk("c2_wait", bus.state, 3'd1);
    tick_burst(9'd289, 5);
    chk("c7_wait", bus.state, 3'd1);
    do_tick(8'd100, 9'd284, 8'd115, 9'd240);
    chk("c8_track", bus.state, 3'd2);
    do_tick(8'd100, 9'd290, 8'd115, 9'd240);
    chk("c9_track", bus.state, 3'd2);
    do_tick(8'd100, 9'd300, 8'd130, 9'd250);
    chk("ret_st", bus.state, 3'd4);
    chk("ret_btn", bus.button, 4'b1001);
    do_tick(8'd100, 9'd310, 8'd120, 9'd240);
    chk("ret2_st", bus.state, 3'd4);
    chk("ret2_btn", bus.button, 4'b1011);
    do_tick(8'd100, 9'd320, 8'd113, 9'd242);
    chk("home_st", bus.state, 3'd0);
    chk("home_btn", bus.button, 4'hF);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/cpu_paddle_driver.md
# cpu_paddle_driver

Computer opponent for the paddle subsystem: drives the active-low 4-bit button interface of a paddle mover so the second paddle tracks and strikes the ball without a human player. Sits between the ball-position logic and an unmodified paddle-mover instance and reads back that instance's X/Y position. All decisions are made once per frame tick; the registered button outputs hold steady between ticks.

## Interface
- `HOME_X`, 115: X rest position.
- `HOME_Y`, 240: Y rest position.
- `DEAD_ZONE`, 2: no X/Y correction while |error| <= DEAD_ZONE.
- `STRIKE_DIST`, 20: Y distance at or below which the paddle lunges at the ball.
- `REACTION_TICKS`, 6: ticks between the ball turning toward the paddle and the start of tracking; 4-bit counter, legal range 0..15.
- `clock` in 1: system clock.
- `reset` in 1: asynchronous, active-low.
- `enable` in 1: 0 forces IDLE.
- `tick` in 1: one-cycle frame strobe.
- `ballXValue` in 8: ball X.
- `ballYValue` in 9: ball Y.
- `paddleXValue` in 8: fed-back paddle X.
- `paddleYValue` in 9: fed-back paddle Y.
- `button` out 4: active-low command to the paddle mover. Bit 0 = down (+Y), bit 1 = up (−Y), bit 2 = left (−X), bit 3 = right (+X).
- `state` out 3: current state for debug and LEDs.

## Operation
- States:
  - IDLE=0: all buttons released.
  - WAIT=1: reaction delay.
  - TRACK=2: X follows the ball, Y steers to HOME_Y.
  - STRIKE=3: X and Y both follow the ball.
  - RETURN=4: X steers to HOME_X, Y steers to HOME_Y.
- Distance:
  - `dist = |ballYValue − paddleYValue|`, 9-bit unsigned. Compute it without signed wrap by comparing first, then subtracting the smaller from the larger.
  - `prevDist` is registered on each tick.
  - `approach` flag: set when dist < prevDist, cleared when dist > prevDist, unchanged when equal.
- Transitions are evaluated only on tick, with priority in the listed order:
  - enable=0 → IDLE from any state.
  - IDLE → WAIT when enable=1 and approach=1; the counter loads 0.
  - WAIT: counter increments each tick. → TRACK when counter == REACTION_TICKS (REACTION_TICKS=0 means TRACK on the next tick). → RETURN if approach drops.
  - TRACK → STRIKE when dist <= STRIKE_DIST. → RETURN when approach=0.
  - STRIKE → RETURN when approach=0. No return to TRACK.
  - RETURN → WAIT when approach=1. → IDLE when the paddle is within DEAD_ZONE of both home coordinates.
- Steering, per axis, using the next-state target:
  - err = target − paddle.
  - err > DEAD_ZONE → press + (bit 0 or bit 3 low).
  - err < −DEAD_ZONE → press − (bit 1 or bit 2 low).
  - otherwise release both.
- Never drive both buttons of one axis low; the assertion is checked in simulation.
- `button` is registered and equals 4'b1111 in IDLE.

## Timing
- Reset values:
  - `button` = 4'b1111.
  - `state` = IDLE.
  - counter = 0.
  - `prevDist` = 9'h1FF.
  - `approach` = 0.
- Reset assertion clears everything immediately, including mid-WAIT or mid-STRIKE; the first tick after release is evaluated from IDLE.
- Latency:
  - A tick in cycle N updates `state` and `button` at edge N+1.
  - Both hold until the next tick.
  - Inputs are sampled only in the tick cycle.
- Ticks closer than 2 cycles apart are legal; each is processed independently.
- `enable` falling between ticks takes effect at the next tick, not earlier.
- tick=0: no register other than the synchronous pipeline changes.

## Structure
- Shared package `pong_pkg`:
  - state encoding constants.
  - button bit indices (BTN_DOWN=0, BTN_UP=1, BTN_LEFT=2, BTN_RIGHT=3).
  - coordinate widths (X 8, Y 9).
- One sub-module, `axis_steer`, parameterised by width:
  - inputs target, position, dead zone.
  - outputs the active-low {minus, plus} pair.
  - instantiated once for X and once for Y.

## Test plan
- Reset with ball (100,300) and paddle (115,240), then release:
  - button=4'b1111 and state=0 until ticks arrive.
- Ball Y steps 300→290→280 per tick with REACTION_TICKS=6:
  - WAIT after the 2nd tick.
  - TRACK after 6 further ticks.
  - X error −15 gives button[2]=0.
- Ball at paddle Y+15 while approaching:
  - STRIKE.
  - ball above the paddle (ballY < paddleY) gives button[1]=0, button[0]=1.
- Ball Y reverses (dist grows) during TRACK:
  - RETURN; steering toward (115,240).
  - IDLE once the paddle is within 2 of home.
- Error of exactly ±DEAD_ZONE on both axes:
  - both pairs released (button=4'b1111).
- enable=0 mid-STRIKE and asynchronous reset mid-WAIT:
  - next tick gives IDLE/1111 for the enable case.
  - reset gives an immediate 1111 and counter=0.
